// File: rtl/output_compare_pkg.sv
// Shared timer definitions: compare-output modes, control FSM states and default width.
package output_compare_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_SET    = 2'b01,
        MODE_CLEAR  = 2'b10,
        MODE_PWM    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Pin level after a compare match in the edge-driven modes; PWM is handled separately.
    function automatic logic match_level(input mode_e mode, input logic cur);
        case (mode)
            MODE_TOGGLE: return ~cur;
            MODE_SET:    return 1'b1;
            MODE_CLEAR:  return 1'b0;
            default:     return cur;
        endcase
    endfunction

endpackage

// File: rtl/output_compare_timebase.sv
// Free-running up-counter that wraps to zero after reaching top; shared by compare and capture paths.
module oc_timebase
    import output_compare_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap
);

    assign wrap = en && (count == top);

    always_comb begin
        // NOTE: default first so every path assigns next_count and no latch is inferred.
        next_count = count;
        if (wrap)
            next_count = '0;
        else if (en)
            next_count = count + WIDTH'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else
            count <= next_count;
    end

endmodule

// File: rtl/output_compare.sv
// Output compare unit: double-buffered compare value, edge/PWM pin drive, sticky match and wrap flags.
module output_compare
    import output_compare_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cmpVal,
    input  logic             loadCmp,
    input  logic [WIDTH-1:0] topVal,
    input  logic [1:0]       mode,
    input  logic             oneShot,
    input  logic             rstOut,
    input  logic             rstIntFlag,
    output logic [WIDTH-1:0] count,
    output logic             sig,
    output logic             intFlag,
    output logic             ovfFlag
);

    state_e           state;
    mode_e            cur_mode;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] next_count;
    logic             run;
    logic             match;
    logic             advance;
    logic             wrap;

    assign cur_mode = mode_e'(mode);
    assign run      = (state == RUN) && en;
    assign match    = run && (count == active);
    // A one-shot match freezes the count at the match value.
    assign advance  = run && !(match && oneShot);

    oc_timebase #(.WIDTH(WIDTH)) u_timebase (
        .clk        (clk),
        .rst        (rst),
        .en         (advance),
        .top        (topVal),
        .count      (count),
        .next_count (next_count),
        .wrap       (wrap)
    );

    // Active compare only changes at a period boundary or while idle; a same-edge load bypasses the shadow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (loadCmp)
                shadow <= cmpVal;
            if (wrap || state == IDLE)
                active <= loadCmp ? cmpVal : shadow;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig <= 1'b0;
        end else if (rstOut) begin
            sig <= 1'b0;
        end else if (run && cur_mode == MODE_PWM) begin
            sig <= (next_count < active);
        end else if (match) begin
            sig <= match_level(cur_mode, sig);
        end
    end

    // Set beats clear so an event landing on the clear edge is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            intFlag <= 1'b0;
            ovfFlag <= 1'b0;
        end else begin
            intFlag <= match || (intFlag && !rstIntFlag);
            ovfFlag <= wrap  || (ovfFlag && !rstIntFlag);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (!en) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= RUN;
                RUN:     if (match && oneShot) state <= DONE;
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/output_compare.md
Name: output_compare

Overview:
- Timer-driven output compare unit, the transmit-side counterpart of the input capture block.
- A free-running counter is compared against a programmed value; on a match the block drives an output pin edge or PWM level and raises a sticky interrupt flag.
- It sits beside the input capture unit in the timer peripheral and shares its flag/clear conventions.

Parameters:
- WIDTH, 4, width of counter, compare and top values.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  counter enable; 0 holds the count and returns the FSM to IDLE.
- cmpVal  input  WIDTH  compare value to load.
- loadCmp  input  1  strobe; captures cmpVal into the shadow register.
- topVal  input  WIDTH  counter wrap value; period is topVal+1.
- mode  input  2  00 toggle, 01 set, 10 clear, 11 PWM.
- oneShot  input  1  1 = stop after the first match.
- rstOut  input  1  synchronous clear of sig.
- rstIntFlag  input  1  synchronous clear of intFlag and ovfFlag.
- count  output  WIDTH  current counter value.
- sig  output  1  compare output pin (registered).
- intFlag  output  1  sticky match flag.
- ovfFlag  output  1  sticky wrap flag.

Behaviour:
- Reset (rst=0, asynchronous): count=0, sig=0, intFlag=0, ovfFlag=0, shadow=0, active compare=0, state IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN when en=1.
  - RUN->DONE on a match with oneShot=1.
  - RUN/DONE->IDLE when en=0.
  - DONE holds count; no further match or wrap events occur.
- Counter: in RUN, count increments each clk. When count==topVal, the next value is 0 and ovfFlag sets. With topVal=0, count stays at 0 and wraps every cycle.
- Compare load: loadCmp=1 writes cmpVal to the shadow register at that edge.
  - Shadow copies to active at a wrap edge, or on any edge while in IDLE.
  - Compare changes are therefore glitch-free within a period.
  - If loadCmp and a wrap occur on the same edge, the new cmpVal goes directly to active.
- Match: match = (state==RUN && count==active). The sig and intFlag updates take effect at that edge and are visible one cycle after count shows the match value.
  - Toggle: sig <= ~sig on match.
  - Set: sig <= 1 on match.
  - Clear: sig <= 0 on match.
  - PWM: every RUN cycle, sig <= (next_count < active).
    - active=0 gives constant 0.
    - active>topVal gives constant 1.
    - Duty = active/(topVal+1).
- Priority on sig: rstOut=1 forces sig=0 and overrides a same-cycle match in all modes.
- Flags: intFlag sets on match; ovfFlag sets on wrap; both clear on rstIntFlag. If a set and a clear occur on the same edge, set wins (no lost event).
- en=0: count, sig and flags hold; only loadCmp, rstOut and rstIntFlag act.
- Reset mid-operation: all state clears immediately, independent of clk.
- All arithmetic is unsigned WIDTH-bit; there is no carry out beyond the wrap.

Decomposition:
- Shared timer package holds:
  - mode encodings MODE_TOGGLE/SET/CLEAR/PWM;
  - FSM state encoding IDLE/RUN/DONE;
  - default WIDTH, shared with input_capture.
- One sub-module, oc_timebase: counter with en, topVal, wrap pulse and count output. Reused by the PWM and capture paths.
- Compare, shadow, output logic, flags and FSM stay in output_compare.

Test Plan:
- Toggle continuous: topVal=9, cmpVal=3 loaded in IDLE, mode=00, en=1.
  - sig toggles the cycle after count==3, every 10 cycles.
  - intFlag=1 after the first match; ovfFlag=1 after count 9->0.
- PWM duty: topVal=7, cmp=2, mode=11.
  - sig high for counts 0-1 and low for 2-7 (2/8 duty).
  - cmp=0 gives sig constant 0; cmp=9 gives sig constant 1.
- Shadow update: PWM topVal=7, cmp=2; pulse loadCmp with cmpVal=5 at count=4.
  - Duty stays 2/8 until the wrap, then becomes 5/8.
- One-shot: mode=01, oneShot=1, cmp=5, topVal=15.
  - sig=1 after the match; count freezes at 5 in DONE.
  - en=0 returns to IDLE; en=1 resumes counting.
- Flag and clear races:
  - rstIntFlag asserted on the match edge leaves intFlag=1.
  - rstOut asserted on a match edge in set mode leaves sig=0.
- Async reset: drop rst mid-count at count=6, away from a clk edge.
  - count, sig, intFlag and ovfFlag read 0 immediately.
  - After release, counting restarts from 0.
